fetch_unit: RTL and testbench



---
 rtl/fetch_unit_pkg.sv | 10 +
 rtl/fetch_unit_if.sv | 26 ++
 rtl/fetch_unit_fifo.sv | 41 ++++
 rtl/fetch_unit.sv | 82 ++++++++
 tb/tb_fetch_unit.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction-fetch front end.
`ifndef XLEN
`define XLEN 32
`endif

package fetch_unit_pkg;
  localparam int unsigned XLEN      = `XLEN;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch bus: decode-side control/results and the instruction BRAM port.
interface fetch_unit_if #(
  parameter int unsigned XLEN = fetch_unit_pkg::XLEN
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            stall;
  logic            imem_en;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic [XLEN-1:0] instrD;
  logic [XLEN-1:0] pcD;
  logic [XLEN-1:0] pcplus4D;
  logic            validD;
  logic            misalign_err;

  modport master (
    input  redirect_valid, redirect_pc, stall, imem_rdata,
    output imem_en, imem_addr, instrD, pcD, pcplus4D, validD, misalign_err
  );

  modport slave (
    output redirect_valid, redirect_pc, stall, imem_rdata,
    input  imem_en, imem_addr, instrD, pcD, pcplus4D, validD, misalign_err
  );
endinterface

// File: rtl/fetch_unit_fifo.sv
// Small fetch FIFO; the head is read straight out of registered storage.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        head,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/fetch_unit.sv
// Fetch PC, BRAM request issue and redirect handling in front of decode.
module fetch_unit #(
  parameter int unsigned     XLEN     = fetch_unit_pkg::XLEN,
  parameter int unsigned     DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(fetch_unit_pkg::RESET_PC)
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master fb
);
  import fetch_unit_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned OW = CW + 1;

  logic [XLEN-1:0]   pc_f;
  logic [XLEN-1:0]   issued_pc;
  logic [XLEN-1:0]   last_pc;
  logic              inflight;
  logic              misalign_err;
  logic [CW-1:0]     count;
  logic [2*XLEN-1:0] head;

  logic              valid_c;
  logic              deq_c;
  logic              push_c;
  logic              issue_c;
  logic [OW-1:0]     occ_c;
  logic [XLEN-1:0]   imem_addr_c;
  logic [XLEN-1:0]   pcd_c;

  // Occupancy after this cycle's dequeue decides whether another request fits.
  always_comb begin
    valid_c     = (count != '0);
    deq_c       = valid_c & ~fb.stall & ~fb.redirect_valid;
    push_c      = inflight & ~fb.redirect_valid;
    occ_c       = OW'(count) + OW'(inflight) - OW'(deq_c);
    issue_c     = ~reset & (fb.redirect_valid | (occ_c < OW'(DEPTH)));
    imem_addr_c = fb.redirect_valid ? {fb.redirect_pc[XLEN-1:2], 2'b00} : pc_f;
    pcd_c       = valid_c ? head[XLEN-1:0] : last_pc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f         <= RESET_PC;
      issued_pc    <= '0;
      inflight     <= 1'b0;
      last_pc      <= '0;
      misalign_err <= 1'b0;
    end else begin
      inflight <= issue_c;
      if (issue_c) begin
        pc_f      <= imem_addr_c + XLEN'(4);
        issued_pc <= imem_addr_c;
      end
      if (valid_c) last_pc <= head[XLEN-1:0];
      if (fb.redirect_valid && (fb.redirect_pc[1:0] != 2'b00)) misalign_err <= 1'b1;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2*XLEN)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_c),
    .pop   (deq_c),
    .flush (fb.redirect_valid),
    .din   ({fb.imem_rdata, issued_pc}),
    .head  (head),
    .count (count)
  );

  assign fb.imem_en      = issue_c;
  assign fb.imem_addr    = imem_addr_c;
  assign fb.validD       = valid_c;
  assign fb.instrD       = valid_c ? head[2*XLEN-1:XLEN] : XLEN'(NOP_INSTR);
  assign fb.pcD          = pcd_c;
  assign fb.pcplus4D     = pcd_c + XLEN'(4);
  assign fb.misalign_err = misalign_err;
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed plan followed by random stall/redirect/reset traffic.
module tb_fetch_unit;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  exp_t        exp_q[$];
  logic [31:0] model_pc;
  logic [31:0] hold_pc;
  logic        mis_m;
  logic        prev_deq, red1, red2, rst1, rst2;

  fetch_unit_if #(.XLEN(32)) bus ();

  fetch_unit #(
    .XLEN     (32),
    .DEPTH    (2),
    .RESET_PC (RST_PC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .fb    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Program image: every word distinct, derived from its byte address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_rdata <= word_at(bus.imem_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic rv, input logic [31:0] rpc, input logic st, input logic rs);
    @(posedge clk);
    #1;
    reset              = rs;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.stall          = st;
    #1;
  endtask

  // Reference stream: decode must see consecutive PCs from the last reset/redirect target.
  always @(negedge clk) begin
    #1;
    if (reset) begin
      exp_q.delete();
      model_pc = RST_PC;
    end else if (bus.redirect_valid) begin
      exp_q.delete();
      model_pc = {bus.redirect_pc[31:2], 2'b00};
    end
    while (exp_q.size() < 4) begin
      exp_q.push_back('{pc: model_pc, instr: word_at(model_pc)});
      model_pc = model_pc + 32'd4;
    end
  end

  // Monitor: compare presented instructions and timing rules against the stream.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (bus.redirect_valid) begin
        chk("redir_en", 32'(bus.imem_en), 32'd1);
        chk("redir_addr", bus.imem_addr, {bus.redirect_pc[31:2], 2'b00});
      end
      if (bus.validD) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_empty: got validD=1 expected empty stream at %0t", $time);
        end else begin
          e = exp_q[0];
          chk("pcD", bus.pcD, e.pc);
          chk("instrD", bus.instrD, e.instr);
          chk("pcplus4D", bus.pcplus4D, e.pc + 32'd4);
          hold_pc = e.pc;
          if (!bus.stall && !bus.redirect_valid) void'(exp_q.pop_front());
        end
      end else begin
        chk("idle_instr", bus.instrD, NOP);
        chk("idle_pc", bus.pcD, hold_pc);
        chk("idle_pc4", bus.pcplus4D, hold_pc + 32'd4);
      end
      if (prev_deq) chk("throughput", 32'(bus.validD), 32'd1);
      if (red1) chk("redir_bubble", 32'(bus.validD), 32'd0);
      if (red2 && !red1 && !rst1 && !rst2) chk("redir_latency", 32'(bus.validD), 32'd1);
      chk("misalign", 32'(bus.misalign_err), 32'(mis_m));
      if (dut.push_c) chk("no_push_when_full", 32'(dut.u_fifo.count == 2'd2), 32'd0);
    end else begin
      chk("reset_en", 32'(bus.imem_en), 32'd0);
      hold_pc = 32'd0;
    end
    prev_deq = !reset && bus.validD && !bus.stall && !bus.redirect_valid;
    red2     = red1;
    rst2     = rst1;
    red1     = bus.redirect_valid && !reset;
    rst1     = reset;
    if (reset) mis_m = 1'b0;
    else if (bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00)) mis_m = 1'b1;
  end

  initial begin
    logic        rv, st, rs;
    logic [31:0] tgt;
    reset              = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    bus.stall          = 1'b0;
    repeat (3) cyc(1'b0, 32'd0, 1'b0, 1'b1);

    // Fill after reset.
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    chk("c1_en", 32'(bus.imem_en), 32'd1);
    chk("c1_addr", bus.imem_addr, 32'd0);
    chk("c1_valid", 32'(bus.validD), 32'd0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    chk("c2_addr", bus.imem_addr, 32'd4);
    chk("c2_valid", 32'(bus.validD), 32'd0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    chk("c3_valid", 32'(bus.validD), 32'd1);
    chk("c3_pc", bus.pcD, 32'd0);
    chk("c3_instr", bus.instrD, word_at(32'd0));
    chk("c3_pc4", bus.pcplus4D, 32'd4);
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    chk("c4_pc", bus.pcD, 32'd4);

    // Stall with head at 8.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 32'd0, 1'b1, 1'b0);
      chk("stall_pc", bus.pcD, 32'd8);
      chk("stall_valid", 32'(bus.validD), 32'd1);
      if (i > 0) chk("stall_en", 32'(bus.imem_en), 32'd0);
    end
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    chk("rel_pc", bus.pcD, 32'd8);
    chk("rel_en", 32'(bus.imem_en), 32'd1);
    chk("rel_addr", bus.imem_addr, 32'd16);
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    chk("rel_pc12", bus.pcD, 32'd12);

    // Redirect to 0x100 while 0x10 is at decode.
    cyc(1'b1, 32'h100, 1'b0, 1'b0);
    chk("pre_redir_pc", bus.pcD, 32'h10);
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    chk("redir_gap", 32'(bus.validD), 32'd0);
    chk("redir_gap_pc", bus.pcD, 32'h10);
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    chk("tgt_pc", bus.pcD, 32'h100);
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    chk("tgt_pc4", bus.pcD, 32'h104);

    // Redirect under stall with the FIFO full.
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
    cyc(1'b1, 32'h200, 1'b1, 1'b0);
    chk("full_pc", bus.pcD, 32'h108);
    chk("full_addr", bus.imem_addr, 32'h200);
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    chk("full_gap", 32'(bus.validD), 32'd0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    chk("full_tgt", bus.pcD, 32'h200);

    // Misaligned redirect.
    cyc(1'b1, 32'h103, 1'b0, 1'b0);
    chk("mis_addr", bus.imem_addr, 32'h100);
    chk("mis_before", 32'(bus.misalign_err), 32'd0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    chk("mis_after", 32'(bus.misalign_err), 32'd1);
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    chk("mis_tgt", bus.pcD, 32'h100);
    chk("mis_sticky", 32'(bus.misalign_err), 32'd1);

    // Reset mid-stream with the FIFO full.
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
    cyc(1'b0, 32'd0, 1'b1, 1'b1);
    cyc(1'b0, 32'd0, 1'b0, 1'b1);
    chk("rst_valid", 32'(bus.validD), 32'd0);
    chk("rst_en", 32'(bus.imem_en), 32'd0);
    chk("rst_mis", 32'(bus.misalign_err), 32'd0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    chk("rst_restart", bus.imem_addr, RST_PC);
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    chk("rst_first_pc", bus.pcD, RST_PC);

    // PC wrap at the top of the address space.
    cyc(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    chk("wrap_pc0", bus.pcD, 32'hFFFF_FFF8);
    chk("wrap_addr", bus.imem_addr, 32'd0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    chk("wrap_pc1", bus.pcD, 32'hFFFF_FFFC);
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    chk("wrap_pc2", bus.pcD, 32'd0);

    // Random traffic checked by the monitor.
    for (int n = 0; n < 3000; n++) begin
      rs  = ($urandom_range(0, 199) == 0);
      st  = ($urandom_range(0, 99) < 30);
      rv  = ($urandom_range(0, 99) < 8);
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else                           tgt = $urandom & 32'h0000_FFFF;
      if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
      cyc(rv, tgt, st, rs);
      if (rs) cyc(1'b0, 32'd0, st, 1'b1);
    end

    repeat (5) cyc(1'b0, 32'd0, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
